// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
// Sequencer between a UART receiver/transmitter pair and a combinational ALU.
// It collects operand A, operand B and the opcode, in that order, from the
// receiver. It then drives the ALU for one settle cycle and launches the
// result through the transmitter.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   rx_data        received byte, valid while rx_done=1
//   rx_done        one-cycle byte-available pulse from the receiver
//   tx_done        one-cycle frame-finished pulse from the transmitter
//   alu_result     combinational ALU output
//   operando_A/B   registered ALU operands
//   cod_operacion  registered ALU opcode (low COD_OP bits of the opcode byte)
//   tx_data        registered result byte for the transmitter
//   tx_start       one-cycle transmitter start pulse
//   busy           high while in EXEC or WAIT_TX
//   drop           one-cycle pulse for each received byte that is discarded
//
// state    | meaning
// ---------+----------------------------------------------------------
// WAIT_A   | idle, next received byte is operand A
// WAIT_B   | next received byte is operand B
// WAIT_OP  | next received byte is the opcode
// EXEC     | ALU settle cycle, result captured and tx_start issued
// WAIT_TX  | transmitter busy, waiting for tx_done

module uart_alu_ctrl #(
    parameter int NBITS  = 8,
    parameter int COD_OP = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NBITS-1:0]  rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [NBITS-1:0]  alu_result,
    output logic [NBITS-1:0]  operando_A,
    output logic [NBITS-1:0]  operando_B,
    output logic [COD_OP-1:0] cod_operacion,
    output logic [NBITS-1:0]  tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              drop
);

    localparam logic [2:0] WAIT_A  = 3'd0;
    localparam logic [2:0] WAIT_B  = 3'd1;
    localparam logic [2:0] WAIT_OP = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] WAIT_TX = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       in_busy_state;

    // The upper opcode byte bits are intentionally discarded.
    generate
        if (NBITS > COD_OP) begin : g_rx_hi
            logic unused_rx_hi;
            assign unused_rx_hi = ^rx_data[NBITS-1:COD_OP];
        end
    endgenerate

    assign in_busy_state = (state == EXEC) || (state == WAIT_TX);

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_A:  if (rx_done) state_nxt = WAIT_B;
            WAIT_B:  if (rx_done) state_nxt = WAIT_OP;
            WAIT_OP: if (rx_done) state_nxt = EXEC;
            EXEC:    state_nxt = WAIT_TX;
            // tx_done wins over a coincident rx_done; that byte is dropped.
            WAIT_TX: if (tx_done) state_nxt = WAIT_A;
            default: state_nxt = WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_A;
            operando_A    <= '0;
            operando_B    <= '0;
            cod_operacion <= '0;
            tx_data       <= '0;
            tx_start      <= 1'b0;
            busy          <= 1'b0;
            drop          <= 1'b0;
        end else begin
            state    <= state_nxt;
            // busy is registered from the next state so it tracks the state exactly.
            busy     <= (state_nxt == EXEC) || (state_nxt == WAIT_TX);
            tx_start <= (state == EXEC);
            drop     <= rx_done && in_busy_state;

            if (rx_done) begin
                case (state)
                    WAIT_A:  operando_A    <= rx_data;
                    WAIT_B:  operando_B    <= rx_data;
                    WAIT_OP: cod_operacion <= rx_data[COD_OP-1:0];
                    default: ;
                endcase
            end

            // Operands have been stable on the ALU for a full cycle by now.
            if (state == EXEC) begin
                tx_data <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] operando_A;
    logic [7:0] operando_B;
    logic [5:0] cod_operacion;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       drop;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] cod;
        logic [7:0] res;
    } exp_t;

    exp_t sb_q[$];

    uart_alu_ctrl #(.NBITS(8), .COD_OP(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .tx_done       (tx_done),
        .alu_result    (alu_result),
        .operando_A    (operando_A),
        .operando_B    (operando_B),
        .cod_operacion (cod_operacion),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .busy          (busy),
        .drop          (drop)
    );

    always #5 clk = ~clk;

    // Combinational ALU stub driven by the DUT's registered operands.
    always_comb begin
        alu_result = 8'hFF;
        case (cod_operacion)
            6'h20: alu_result = operando_A + operando_B;
            6'h22: alu_result = operando_A - operando_B;
            6'h24: alu_result = operando_A & operando_B;
            6'h25: alu_result = operando_A | operando_B;
            6'h26: alu_result = operando_A ^ operando_B;
            6'h02: alu_result = operando_A >> operando_B;
            6'h03: alu_result = 8'($signed(operando_A) >>> operando_B);
            default: alu_result = 8'hFF;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every tx_start pulse must match the oldest pending expectation.
    initial begin
        logic prev_start;
        exp_t e;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && tx_start) begin
                check("tx_start_single_cycle", {31'd0, prev_start}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("tx_start_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("mon_operando_A", {24'd0, operando_A}, {24'd0, e.a});
                    check("mon_operando_B", {24'd0, operando_B}, {24'd0, e.b});
                    check("mon_cod_operacion", {26'd0, cod_operacion}, {26'd0, e.cod});
                    check("mon_tx_data", {24'd0, tx_data}, {24'd0, e.res});
                    check("mon_busy", {31'd0, busy}, 32'd1);
                end
            end
            prev_start = tx_start;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // Sends the opcode and checks EXEC entry and tx_start latency, leaving the DUT in WAIT_TX.
    task automatic send_op_and_launch(input logic [7:0] op, input logic [5:0] exp_cod);
        send_byte(op);
        check("cod_after_op_edge", {26'd0, cod_operacion}, {26'd0, exp_cod});
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("tx_start_not_yet", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        check("tx_start_latency", {31'd0, tx_start}, 32'd1);
    endtask

    task automatic finish_tx();
        @(negedge clk);
        check("tx_start_low", {31'd0, tx_start}, 32'd0);
        check("busy_wait_tx", {31'd0, busy}, 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input logic [5:0] exp_cod, input logic [7:0] exp_res);
        sb_q.push_back({a, b, exp_cod, exp_res});
        send_byte(a);
        send_byte(b);
        send_op_and_launch(op, exp_cod);
        finish_tx();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A"},     {24'd0, operando_A}, 32'd0);
        check({tag, "_B"},     {24'd0, operando_B}, 32'd0);
        check({tag, "_cod"},   {26'd0, cod_operacion}, 32'd0);
        check({tag, "_tx"},    {24'd0, tx_data}, 32'd0);
        check({tag, "_start"}, {31'd0, tx_start}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_drop"},  {31'd0, drop}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        // rx_done during reset must have no effect.
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = 8'h5A;
        @(negedge clk);
        rx_done = 1'b0;
        reset   = 1'b0;
        check_all_zero("reset");

        // ADD, SUB signed, SRA, opcode truncation, unknown opcode
        run_triple(8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
        run_triple(8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);
        run_triple(8'h80, 8'h02, 8'h03, 6'h03, 8'hE0);
        run_triple(8'h0F, 8'hF0, 8'hE5, 6'h25, 8'hFF);
        run_triple(8'h01, 8'h01, 8'h3F, 6'h3F, 8'hFF);

        // tx_done outside WAIT_TX is ignored: a stray pulse in WAIT_B must not disturb the triple.
        sb_q.push_back({8'h09, 8'h06, 6'h22, 8'h03});
        send_byte(8'h09);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        send_byte(8'h06);
        send_op_and_launch(8'h22, 6'h22);
        // Drop while in WAIT_TX
        send_byte(8'h77);
        check("drop_wait_tx", {31'd0, drop}, 32'd1);
        check("drop_A_kept", {24'd0, operando_A}, 32'h09);
        check("drop_B_kept", {24'd0, operando_B}, 32'h06);
        check("drop_cod_kept", {26'd0, cod_operacion}, 32'h22);
        check("drop_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("drop_one_cycle", {31'd0, drop}, 32'd0);
        // rx_done coincident with tx_done
        rx_data = 8'h99;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("drop_coincident", {31'd0, drop}, 32'd1);
        check("busy_after_coincident", {31'd0, busy}, 32'd0);
        check("coincident_A_kept", {24'd0, operando_A}, 32'h09);
        sb_q.push_back({8'h40, 8'h01, 6'h20, 8'h41});
        send_byte(8'h40);
        check("next_byte_is_A", {24'd0, operando_A}, 32'h40);
        check("drop_cleared", {31'd0, drop}, 32'd0);
        send_byte(8'h01);
        send_op_and_launch(8'h20, 6'h20);
        finish_tx();

        // Reset mid-operation
        send_byte(8'h11);
        send_byte(8'h22);
        check("partial_B", {24'd0, operando_B}, 32'h22);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midreset");
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stray_tx_done_busy", {31'd0, busy}, 32'd0);
        run_triple(8'h01, 8'h02, 8'h20, 6'h20, 8'h03);

        // Back-to-back bytes, then a second triple right after tx_done
        run_triple(8'h0A, 8'h05, 8'h24, 6'h24, 8'h00);
        run_triple(8'hC3, 8'h3C, 8'h26, 6'h26, 8'hFF);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Sequencer between the UART receiver/transmitter pair and the combinational ALU. It collects three bytes from the UART receiver: operand A, operand B, then the opcode. It drives the registered values onto the ALU inputs and waits one settle cycle. It then launches the ALU result through the UART transmitter and returns for the next operand triple once transmission completes.

## Interface
- `NBITS`, 8: data width of operands, result and UART bytes; must be ≥ `COD_OP`.
- `COD_OP`, 6: opcode width driven to the ALU.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  `NBITS`  received byte; valid only while `rx_done`=1.
- `rx_done`  in  1  one-cycle pulse from the UART receiver, byte available.
- `tx_done`  in  1  one-cycle pulse from the UART transmitter, frame finished.
- `alu_result`  in  `NBITS`  combinational ALU output.
- `operando_A`  out  `NBITS`  registered operand A to the ALU.
- `operando_B`  out  `NBITS`  registered operand B to the ALU.
- `cod_operacion`  out  `COD_OP`  registered opcode to the ALU.
- `tx_data`  out  `NBITS`  registered result byte for the transmitter.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `busy`  out  1  high in EXEC and WAIT_TX.
- `drop`  out  1  one-cycle pulse when a received byte is discarded.

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- WAIT_A: when `rx_done`=1, latch `operando_A` <= `rx_data` and go to WAIT_B.
- WAIT_B: when `rx_done`=1, latch `operando_B` <= `rx_data` and go to WAIT_OP.
- WAIT_OP: when `rx_done`=1, latch `cod_operacion` <= `rx_data[COD_OP-1:0]` and go to EXEC. Upper bits of the byte are discarded with no validity check; unknown opcodes yield the ALU default (all ones) and are transmitted as-is.
- EXEC: lasts exactly one cycle. `tx_data` <= `alu_result` and `tx_start` <= 1, then go to WAIT_TX.
- WAIT_TX: when `tx_done`=1, go to WAIT_A. Operand and opcode registers are not cleared and keep driving the ALU until overwritten.
- No `rx_done` wait states other than WAIT_A, WAIT_B and WAIT_OP.
- `rx_done`=1 in EXEC or WAIT_TX: the byte is ignored, no register changes, and `drop`=1 for the following cycle.
- `rx_done` and `tx_done` both high in WAIT_TX: the byte is dropped and the FSM still moves to WAIT_A, so the next `rx_done` is operand A.
- `tx_done` outside WAIT_TX is ignored.
- No arithmetic is done in this block; data passes bit-exact.

## Timing
- Reset values:
  - state = WAIT_A
  - `operando_A` = 0, `operando_B` = 0, `cod_operacion` = 0, `tx_data` = 0
  - `tx_start` = 0, `busy` = 0, `drop` = 0
- Reset dominates all other inputs in the same cycle.
- Reset mid-operation aborts the triple, and partial operands are lost. A transmitter frame already started is not cancelled, and its later `tx_done` is ignored in WAIT_A.
- Latency: opcode `rx_done` sampled at edge n gives state EXEC and the new `cod_operacion` after edge n. `tx_start`=1 with valid `tx_data` follows after edge n+1, and `tx_start` returns to 0 after edge n+2.
- `tx_start` is never high for more than one cycle and is never reasserted before `tx_done`.
- `busy` rises after edge n, falls after the edge that samples `tx_done`, and is registered.
- `drop` is registered and lasts one cycle per dropped byte.
- The FSM accepts at most one received byte per cycle. Back-to-back `rx_done` pulses on consecutive cycles advance WAIT_A→WAIT_B→WAIT_OP on consecutive edges.

## Test plan
- ADD: rx bytes 0x05, 0x03, 0x20 → `cod_operacion`=0x20, `tx_start` pulse 2 edges after the opcode is sampled, `tx_data`=0x08; `tx_done` → state WAIT_A, `busy`=0.
- SUB signed and SRA:
  - rx 0x03, 0x05, 0x22 → `tx_data`=0xFE.
  - rx 0x80, 0x02, 0x03 → `tx_data`=0xE0.
- Opcode truncation and unknown opcode:
  - rx 0x0F, 0xF0, 0xE5 → `cod_operacion`=0x25 (OR), `tx_data`=0xFF.
  - rx 0x01, 0x01, 0x3F → `tx_data`=0xFF (ALU default).
- Drop while busy: send a triple, then pulse `rx_done` with 0x77 in WAIT_TX → `drop` one cycle, operands unchanged. Pulse `rx_done` coincident with `tx_done` → `drop`=1, state WAIT_A, and the next byte lands in `operando_A`.
- Reset mid-op: rx 0x11, 0x22, then `reset` for one cycle → all outputs zero, state WAIT_A. A stray `tx_done` afterwards is ignored. A new triple 0x01, 0x02, 0x20 yields `tx_data`=0x03.
- Back-to-back: three `rx_done` pulses on consecutive cycles (0x0A, 0x05, 0x24) → `tx_data`=0x00 (AND). A second triple immediately after `tx_done` is processed with no lost bytes.
